// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Request/response bundle for the bit-serial adder controller.
//   Request side : in_valid, in_ready, op_a, op_b, op_sub
//   Response side: out_valid, out_ready, result, carry_out, overflow
//   Status       : busy
//   master modport: the requester/consumer (drives operands, out_ready).
//   slave modport : the controller itself.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid,
      output op_a,
      output op_b,
      output op_sub,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  carry_out,
      input  overflow,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  op_a,
      input  op_b,
      input  op_sub,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output carry_out,
      output overflow,
      output busy
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller: one full adder, one operand bit per clock,
//   LSB first. A request is accepted in IDLE, WIDTH shift cycles follow, and
//   the result is held in DONE until the consumer takes it.
//
//   Ports:
//     clk    - sole clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - serial_add_ctrl_if.slave (handshake, operands, result, flags)
//
//   Parameter WIDTH: operand/result width, 2..64.
//
//   Build option: define SERIAL_SUB_EN to add subtraction (op_sub = 1 gives
//   a-b; carry_out then reads as "no borrow"). Without it op_sub is ignored
//   and the datapath only adds.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request (in_ready = 1)
//   SHIFT | one bit added per cycle, counter 0..WIDTH-1 (busy = 1)
//   DONE  | result/flags held until out_ready (out_valid = 1)

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_add_ctrl_if.slave   bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic             carry_q;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry_out_q;
   logic             overflow_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             accept;
   logic             fa_b;
   logic             fa_sum;
   logic             fa_cout;
   logic             carry_init;

   assign accept = bus.in_valid && in_ready_q;

`ifdef SERIAL_SUB_EN
   logic sub_q;

   // Subtraction is a + ~b + 1: invert B at the adder and seed the carry.
   assign fa_b       = b_sr[0] ^ sub_q;
   assign carry_init = bus.op_sub;

   always_ff @(posedge clk) begin
      if (accept) begin
         sub_q <= bus.op_sub;
      end
   end
`else
   assign fa_b       = b_sr[0];
   assign carry_init = 1'b0;
`endif

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (fa_b),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Operand shift registers carry no reset: they are loaded on every
   // acceptance and only read while in SHIFT.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sr <= bus.op_a;
         b_sr <= bus.op_b;
      end else if (busy_q) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         carry_q     <= 1'b0;
         res_sr      <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= SHIFT;
                  bit_cnt    <= '0;
                  carry_q    <= carry_init;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            SHIFT: begin
               res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
               carry_q <= fa_cout;
               if (bit_cnt == LAST_BIT) begin
                  // MSB position: carry-in is carry_q, carry-out is fa_cout.
                  bit_cnt     <= '0;
                  carry_out_q <= fa_cout;
                  overflow_q  <= carry_q ^ fa_cout;
                  state       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state       <= IDLE;
               bit_cnt     <= '0;
               carry_q     <= 1'b0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.result    = res_sr;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed and back-to-back stimulus for serial_add_ctrl (WIDTH = 32).
//   The driver pushes expected results into a scoreboard queue at acceptance;
//   an independent monitor pops and compares whenever a result is handed off.
module tb_serial_add_ctrl;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      int           acc;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Arithmetic reference: plain wide add of a and (possibly inverted) b.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
      logic         s_eff;
      logic [W-1:0] bb;
      logic [W:0]   sum;
`ifdef SERIAL_SUB_EN
      s_eff = s;
`else
      s_eff = 1'b0;
      if (s) s_eff = 1'b0;
`endif
      bb  = s_eff ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s_eff};
      r   = sum[W-1:0];
      c   = sum[W];
      v   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
   endfunction

   task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] r, input logic c, input logic v);
      vec_t x;
      x.a = a; x.b = b; x.s = s; x.r = r; x.c = c; x.v = v;
      vt.push_back(x);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] r, input logic c, input logic v, output int acc);
      bit   done;
      logic rdy;
      exp_t e;
      done = 1'b0;
      acc  = -1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_sub   = s;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         rdy = bus.in_ready;
         @(negedge clk);
         if (rdy) begin
            done  = 1'b1;
            acc   = cyc;
            e.r   = r;
            e.c   = c;
            e.v   = v;
            e.acc = cyc;
            sb.push_back(e);
         end
      end
      if (!done) chk("accept_timeout", 64'd1, 64'd0);
      // Operands change right after acceptance; the result must not care.
      bus.in_valid = 1'b0;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      bus.op_sub   = ~s;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);
   endtask

   // Monitor
   bit           seen;
   bit           chk_idle;
   logic [W-1:0] cap_r;
   logic         cap_c;
   logic         cap_v;

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst_n) begin
         seen     = 1'b0;
         chk_idle = 1'b0;
      end else begin
         if (chk_idle) begin
            chk_idle = 1'b0;
            chk("idle_after_handoff", 64'({bus.in_ready, bus.out_valid}), 64'b10);
         end
         if (bus.out_valid) begin
            if (!seen) begin
               seen  = 1'b1;
               cap_r = bus.result;
               cap_c = bus.carry_out;
               cap_v = bus.overflow;
               if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
               // accept edge plus WIDTH shift edges
               else chk("latency", 64'(cyc - sb[0].acc), 64'(W));
            end else begin
               chk("hold_result", 64'(bus.result), 64'(cap_r));
               chk("hold_flags", 64'({bus.carry_out, bus.overflow}), 64'({cap_c, cap_v}));
               chk("no_accept_in_done", 64'({bus.in_ready, bus.busy}), 64'd0);
            end
            if (bus.out_ready) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("result", 64'(bus.result), 64'(e.r));
                  chk("carry_out", 64'(bus.carry_out), 64'(e.c));
                  chk("overflow", 64'(bus.overflow), 64'(e.v));
               end
               seen     = 1'b0;
               chk_idle = 1'b1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int           acc;
      int           prev;
      bit           saw;
      logic [W-1:0] ra, rb, rr;
      logic         rs, rc, rv;

      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_sub    = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ready_valid_busy", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_flags", 64'({bus.carry_out, bus.overflow}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

      add_vec(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
      add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      add_vec(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
`ifdef SERIAL_SUB_EN
      add_vec(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      add_vec(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      add_vec(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      add_vec(32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
`else
      // op_sub must be ignored: still an add
      add_vec(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
`endif
      foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].s, vt[i].r, vt[i].c, vt[i].v, acc);
      wait_drain();

      // Consumer stalls in DONE; a second request must be ignored.
      bus.out_ready = 1'b0;
      send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, acc);
      for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
      chk("done_reached", 64'(bus.out_valid), 64'd1);
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'h0BAD_F00D;
      bus.in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("stall_ready_busy", 64'({bus.in_ready, bus.busy, bus.out_valid}), 64'b001);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("idle_next_edge", 64'({bus.in_ready, bus.out_valid}), 64'b10);
      saw = 1'b0;
      repeat (W + 5) begin
         @(negedge clk);
         saw |= bus.out_valid;
      end
      chk("ignored_request", 64'(saw), 64'd0);
      wait_drain();

      // Reset in the middle of SHIFT with counter at 12.
      send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0, acc);
      repeat (12) @(negedge clk);
      chk("mid_shift_busy", 64'({bus.busy, bus.in_ready}), 64'b10);
      #1 rst_n = 1'b0;
      sb.delete();
      #2;
      chk("abort_ready_valid_busy", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      chk("abort_result", 64'(bus.result), 64'd0);
      chk("abort_flags", 64'({bus.carry_out, bus.overflow}), 64'd0);
      #1 rst_n = 1'b1;
      saw = 1'b0;
      repeat (2 * W) begin
         @(negedge clk);
         saw |= bus.out_valid;
      end
      chk("no_valid_after_abort", 64'(saw), 64'd0);
      send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, acc);
      wait_drain();

      // Back-to-back stream with out_ready held high.
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, rr, rc, rv);
         send(ra, rb, rs, rr, rc, rv, acc);
         if (i > 0) chk("spacing", 64'(acc - prev), 64'(W + 2));
         prev = acc;
      end
      wait_drain();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request carries operands.
REQ-005 in_ready  output  1  controller can accept a request.
REQ-006 op_a  input  WIDTH  first operand.
REQ-007 op_b  input  WIDTH  second operand.
REQ-008 op_sub  input  1  1 = a-b; used only when SERIAL_SUB_EN is defined (REQ-031).
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 carry_out  output  1  carry out of the MSB position.
REQ-013 overflow  output  1  signed two's-complement overflow.
REQ-014 busy  output  1  high while in state SHIFT.

Function
REQ-015 The block SHALL compute with exactly one full_adder instance (a, b, cin -> sum, cout), one bit per cycle, LSB first; no parallel adder is allowed.
REQ-016 FSM states: IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==SHIFT).
REQ-017 IDLE: on in_valid && in_ready, latch op_a and op_b into shift registers, clear bit counter to 0, load the carry flop with 0 (add) and go to SHIFT.
REQ-018 SHIFT: each cycle, feed bit 0 of the A and B shift registers and the carry flop into the full adder, shift A and B right by one, shift adder sum into result MSB (result shifts right), register adder cout into carry flop, increment counter.
REQ-019 When the counter equals WIDTH-1 at a clock edge in SHIFT, that edge SHALL process the final bit and move to DONE.
REQ-020 Latency: accept edge to out_valid high = exactly WIDTH+1 rising edges after acceptance is sampled (WIDTH SHIFT cycles, then DONE).
REQ-021 In DONE, carry_out = final carry flop; overflow = cin XOR cout of the MSB bit position, captured at the final SHIFT edge.
REQ-022 DONE: result, carry_out, overflow SHALL stay stable until out_valid && out_ready, then go to IDLE; no new request accepted in the same cycle (one bubble).
REQ-023 in_valid while not in IDLE SHALL be ignored; op_a/op_b/op_sub changes after acceptance SHALL NOT affect the result.
REQ-024 out_ready held high continuously SHALL yield back-to-back throughput of one result per WIDTH+2 cycles.
REQ-025 Counter width SHALL be clog2(WIDTH) bits minimum; no wrap inside one operation.
REQ-026 Result SHALL wrap modulo 2^WIDTH (e.g. all-ones + 1 = 0, carry_out = 1).

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force state IDLE, counter 0, carry flop 0, result 0, carry_out 0, overflow 0.
REQ-028 Reset asserted in SHIFT or DONE SHALL abort the operation; no out_valid pulse follows deassertion.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.
REQ-030 Operand shift registers need not be reset but SHALL NOT influence any output before a new acceptance.

Configuration
REQ-031 Macro SERIAL_SUB_EN: when defined, op_sub is latched on acceptance; if 1, B bits are inverted before the adder and the carry flop loads 1, giving a-b; carry_out then means no-borrow (a >= b unsigned).
REQ-032 Without SERIAL_SUB_EN, op_sub SHALL be ignored, no inverter logic is present, and the block only adds.

Verification
REQ-033 WIDTH=32, a=0x0000_0005, b=0x0000_0003, add -> out_valid after 33 edges, result=0x8, carry_out=0, overflow=0.
REQ-034 a=0xFFFF_FFFF, b=0x0000_0001 -> result=0x0, carry_out=1, overflow=0; a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1.
REQ-035 SERIAL_SUB_EN defined, a=3, b=5, op_sub=1 -> result=0xFFFF_FFFE, carry_out=0; a=5, b=3 -> result=2, carry_out=1.
REQ-036 out_ready held low 10 cycles in DONE -> result stable, in_ready=0, second in_valid ignored; out_ready high -> IDLE next edge.
REQ-037 rst_n pulsed low mid-SHIFT (counter=12) -> outputs cleared asynchronously, no out_valid afterwards, next request computes correctly.
REQ-038 Random operands, out_ready tied 1, 1000 back-to-back ops -> each result matches reference model, spacing exactly WIDTH+2 cycles.
